int_dispatch_buf: RTL and testbench
===================================

Name: int_dispatch_buf

Overview:
- Dispatch-side driver of the dispatch-to-integer-RS handshake; it is the producer that feeds int_rs.
- Accepts renamed uop bundles (ID_WIDTH lanes) from rename into a small bundle FIFO.
- Presents the head bundle to the integer RS and releases it when the RS asserts ready.
- Snoops the CDB so that wakeups occurring while a uop waits here, or in the cycle it is pushed, are never lost.

Parameters:
- ID_WIDTH, 2, lanes per bundle (from cpu_params).
- CDB_WIDTH, 2, number of CDB broadcast ports (from cpu_params).
- DEPTH, 2, bundle slots in the FIFO; must be >= 1, need not be a power of 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush (mispredict); discards all buffered bundles.
- rn_valid  in  ID_WIDTH  per-lane valid from rename.
- rn_uop  in  ID_WIDTH x uop_t  renamed uops.
- rn_ready  out  1  buffer can accept a bundle this cycle.
- to_rs  ds_rs_itf.ds  -  drives valid[ID_WIDTH] and uop[ID_WIDTH]; samples ready.
- cdb  cdb_itf.rs [CDB_WIDTH]  -  samples valid and rd_phy.

Behaviour:
- Storage:
  - DEPTH slots, each holding ID_WIDTH uop_t plus ID_WIDTH lane-valid bits.
  - head/tail pointers wrap explicitly at DEPTH-1 -> 0.
  - count is clog2(DEPTH+1) bits wide.
- Reset:
  - count=0, head=tail=0, all stored lane-valids=0.
  - to_rs.valid is all 0 during and after reset.
  - rn_ready=0 while rst is high; rn_ready=1 in the first cycle after reset.
- rn_ready:
  - rn_ready = (count < DEPTH), derived only from registered state.
  - No combinational path from to_rs.ready to rn_ready.
- Enqueue:
  - Occurs when rn_ready && |rn_valid && !flush.
  - Writes the bundle at tail and increments tail.
  - A bundle with all lanes invalid is not enqueued.
  - Lane positions are preserved; no compaction, since the RS pushes valid lanes in lane order.
- Output:
  - to_rs.valid[i] = (count != 0) && head.lane_valid[i].
  - to_rs.uop[i] = head uop[i], with CDB bypass applied (see below).
- Dequeue:
  - Occurs when count != 0 && to_rs.ready && !flush.
  - The whole head bundle leaves in one cycle, because RS ready guarantees >= ID_WIDTH free slots.
  - Increments head.
- Count update:
  - Enqueue and dequeue in the same cycle: count unchanged.
  - Enqueue only: +1.
  - Dequeue only: -1.
- Throughput: with DEPTH=2 and the RS always ready, one bundle per cycle sustained; enqueue-to-valid latency is 1 cycle.
- CDB snoop, stored entries:
  - Each cycle, for every valid stored lane and every k with cdb[k].valid:
    - rs1_phy == cdb[k].rd_phy -> rs1_valid <= 1.
    - rs2_phy == cdb[k].rd_phy -> rs2_valid <= 1.
  - Applies regardless of op1_sel/op2_sel.
  - A bit already 1 is never cleared.
- CDB snoop, enqueue: the same comparison is applied to the incoming rn_uop, so a broadcast in the enqueue cycle is captured.
- CDB bypass on output:
  - to_rs.uop[i].rs1_valid/rs2_valid = stored bit OR a same-cycle CDB match.
  - Required because the RS latches pushed uops without snooping that cycle's CDB.
- Flush:
  - Next cycle: count=0, head=tail=0, to_rs.valid=0.
  - Flush has priority over a same-cycle enqueue or dequeue.
  - Any transfer asserted to the RS in the flush cycle is the RS's responsibility to drop; rn_uop in that cycle is discarded.
- Full: rn_ready=0, no enqueue, no overwrite; to_rs.ready still dequeues normally.
- Empty: to_rs.valid=0 and to_rs.uop is don't-care.
- to_rs.ready is ignored when count==0.

Decomposition:
- Add ds_bundle_t (uop_t array plus lane-valid vector) to uop_types.
- Add DISPATCH_DEPTH to cpu_params.
- One natural sub-module, uop_cdb_snoop: combinational uop_t plus cdb inputs -> uop_t with updated rs1_valid/rs2_valid.
  - Instantiated per stored lane, per incoming lane, and per output lane.
- The FIFO control stays in int_dispatch_buf.

Test Plan:
- Reset release, RS ready=1: one cycle after rst drops, rn_ready=1 and to_rs.valid=00.
- Enqueue bundle {lane0 rs1_phy=5, rs1_valid=0; lane1 valid} in cycle 0 -> to_rs.valid=11 in cycle 1 with uop fields unchanged; dequeued in cycle 1.
- Hold RS ready=0 and enqueue 2 bundles -> count=2, rn_ready=0, and the 3rd rename bundle is not accepted.
  - Release ready for 1 cycle -> bundle A drains, rn_ready=1 next cycle, and B is at head with order preserved.
- Buffered uop rs2_phy=9, rs2_valid=0, RS ready=0; cdb[1] valid with rd_phy=9 for 1 cycle -> stored rs2_valid=1 and stays 1 after the CDB drops.
- Same-cycle bypass: head uop rs1_phy=12, rs1_valid=0; cdb[0] rd_phy=12 in the dequeue cycle -> to_rs.uop[0].rs1_valid=1 that cycle.
- Flush concurrent with an enqueue while count=1 -> next cycle count=0, to_rs.valid=00, rn_ready=1; the flushed bundles never appear.

Source files
------------

// File: rtl/int_dispatch_buf_pkg.sv
// Shared types and CPU-level parameters for the dispatch buffer and the
// integer RS handshake: the renamed uop format and the buffered bundle.
package int_dispatch_buf_pkg;

   localparam int CP_ID_WIDTH    = 2;
   localparam int CP_CDB_WIDTH   = 2;
   localparam int DISPATCH_DEPTH = 2;
   localparam int PHY_W          = 6;

   typedef struct packed {
      logic [7:0]       opcode;
      logic [PHY_W-1:0] rd_phy;
      logic [PHY_W-1:0] rs1_phy;
      logic [PHY_W-1:0] rs2_phy;
      logic             op1_sel;
      logic             op2_sel;
      logic             rs1_valid;
      logic             rs2_valid;
   } uop_t;

   typedef struct packed {
      uop_t [CP_ID_WIDTH-1:0] uop;
      logic [CP_ID_WIDTH-1:0] lane_valid;
   } ds_bundle_t;

endpackage

// File: rtl/int_dispatch_buf_itf.sv
// Dispatch-to-RS bundle handshake and a single CDB broadcast port.
interface ds_rs_itf;
   import int_dispatch_buf_pkg::*;

   logic [CP_ID_WIDTH-1:0] valid;
   uop_t [CP_ID_WIDTH-1:0] uop;
   logic                   ready;

   modport ds (output valid, output uop, input ready);
   modport rs (input valid, input uop, output ready);
endinterface

interface cdb_itf;
   import int_dispatch_buf_pkg::*;

   logic             valid;
   logic [PHY_W-1:0] rd_phy;

   modport cdb (output valid, output rd_phy);
   modport rs  (input valid, input rd_phy);
endinterface

// File: rtl/uop_cdb_snoop.sv
// Marks a uop's source operands ready when any valid CDB port broadcasts
// the matching physical register. Purely combinational.
module uop_cdb_snoop
   import int_dispatch_buf_pkg::*;
#(
   parameter int CDB_WIDTH = CP_CDB_WIDTH
) (
   input  uop_t                            uop_in,
   input  logic [CDB_WIDTH-1:0]            cdb_valid,
   input  logic [CDB_WIDTH-1:0][PHY_W-1:0] cdb_rd_phy,
   output uop_t                            uop_out
);

   // Set ready bits on a tag match; never clear a bit that is already set.
   always_comb begin
      uop_out = uop_in;
      for (int k = 0; k < CDB_WIDTH; k++) begin
         if (cdb_valid[k]) begin
            if (uop_in.rs1_phy == cdb_rd_phy[k]) uop_out.rs1_valid = 1'b1;
            if (uop_in.rs2_phy == cdb_rd_phy[k]) uop_out.rs2_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/int_dispatch_buf.sv
// Bundle FIFO between rename and the integer RS. Holds whole bundles with
// lane positions preserved, releases the head bundle when the RS is ready,
// and keeps operand ready bits current by snooping the CDB.
module int_dispatch_buf
   import int_dispatch_buf_pkg::*;
#(
   parameter int ID_WIDTH  = CP_ID_WIDTH,
   parameter int CDB_WIDTH = CP_CDB_WIDTH,
   parameter int DEPTH     = DISPATCH_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic [ID_WIDTH-1:0] rn_valid,
   input  uop_t [ID_WIDTH-1:0] rn_uop,
   output logic                rn_ready,
   ds_rs_itf.ds                to_rs,
   cdb_itf.rs                  cdb [CDB_WIDTH]
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [CDB_WIDTH-1:0]            cdb_valid;
   logic [CDB_WIDTH-1:0][PHY_W-1:0] cdb_rd_phy;

   uop_t [ID_WIDTH-1:0] slot_uop     [DEPTH];
   uop_t [ID_WIDTH-1:0] slot_snooped [DEPTH];
   logic [ID_WIDTH-1:0] slot_valid   [DEPTH];
   uop_t [ID_WIDTH-1:0] in_snooped;
   uop_t [ID_WIDTH-1:0] out_snooped;

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             enq;
   logic             deq;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_cdb
      assign cdb_valid[k]  = cdb[k].valid;
      assign cdb_rd_phy[k] = cdb[k].rd_phy;
   end

   for (genvar i = 0; i < ID_WIDTH; i++) begin : g_lane
      for (genvar d = 0; d < DEPTH; d++) begin : g_slot
         uop_cdb_snoop #(.CDB_WIDTH(CDB_WIDTH)) u_slot_snoop (
            .uop_in     (slot_uop[d][i]),
            .cdb_valid  (cdb_valid),
            .cdb_rd_phy (cdb_rd_phy),
            .uop_out    (slot_snooped[d][i])
         );
      end

      uop_cdb_snoop #(.CDB_WIDTH(CDB_WIDTH)) u_in_snoop (
         .uop_in     (rn_uop[i]),
         .cdb_valid  (cdb_valid),
         .cdb_rd_phy (cdb_rd_phy),
         .uop_out    (in_snooped[i])
      );

      uop_cdb_snoop #(.CDB_WIDTH(CDB_WIDTH)) u_out_snoop (
         .uop_in     (slot_uop[head][i]),
         .cdb_valid  (cdb_valid),
         .cdb_rd_phy (cdb_rd_phy),
         .uop_out    (out_snooped[i])
      );
   end

   assign empty    = (count == '0);
   assign rn_ready = !rst && (count < CNT_W'(DEPTH));
   assign enq      = rn_ready && (|rn_valid) && !flush;
   assign deq      = !empty && to_rs.ready && !flush;

   assign to_rs.valid = (!rst && !empty) ? slot_valid[head] : '0;
   assign to_rs.uop   = out_snooped;

   // FIFO control: pointers, occupancy and lane-valid bits; flush empties it.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
         for (int d = 0; d < DEPTH; d++) slot_valid[d] <= '0;
      end else begin
         if (enq) begin
            slot_valid[tail] <= rn_valid;
            tail             <= next_ptr(tail);
         end
         if (deq) head <= next_ptr(head);
         if (enq && !deq)      count <= count + CNT_W'(1);
         else if (!enq && deq) count <= count - CNT_W'(1);
      end
   end

   // Uop storage: every slot absorbs CDB wakeups, the tail takes the new bundle.
   always_ff @(posedge clk) begin
      for (int d = 0; d < DEPTH; d++) slot_uop[d] <= slot_snooped[d];
      if (enq) slot_uop[tail] <= in_snooped;
   end

endmodule

// File: tb/tb_int_dispatch_buf.sv
// Scoreboard bench for int_dispatch_buf: directed bundles push their
// hand-computed RS view into a queue; a monitor compares each RS transfer.
module tb_int_dispatch_buf;
   import int_dispatch_buf_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic [1:0] rn_valid;
   uop_t [1:0] rn_uop;
   logic       rn_ready;

   ds_rs_itf rs_if ();
   cdb_itf   cdb_if [CP_CDB_WIDTH] ();

   int         checks = 0;
   int         errors = 0;
   ds_bundle_t exp_q[$];
   ds_bundle_t mon_exp;

   int_dispatch_buf dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .rn_valid (rn_valid),
      .rn_uop   (rn_uop),
      .rn_ready (rn_ready),
      .to_rs    (rs_if),
      .cdb      (cdb_if)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   function automatic uop_t make_uop(input logic [7:0] op, input logic [5:0] rd,
                                     input logic [5:0] s1, input logic [5:0] s2,
                                     input logic v1, input logic v2);
      uop_t u;
      u.opcode = op; u.rd_phy = rd; u.rs1_phy = s1; u.rs2_phy = s2;
      u.op1_sel = 1'b1; u.op2_sel = 1'b0; u.rs1_valid = v1; u.rs2_valid = v2;
      return u;
   endfunction

   function automatic ds_bundle_t make_bundle(input uop_t u1, input uop_t u0, input logic [1:0] v);
      ds_bundle_t b;
      b.uop = {u1, u0};
      b.lane_valid = v;
      return b;
   endfunction

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] v, input uop_t u1, input uop_t u0,
                                 input logic rdy, input logic fl);
      @(posedge clk);
      #1;
      rn_valid    = v;
      rn_uop      = {u1, u0};
      rs_if.ready = rdy;
      flush       = fl;
   endtask

   // Monitor: every accepted RS transfer must match the oldest expected bundle.
   always @(negedge clk) begin
      if (!rst && !flush && rs_if.ready && (|rs_if.valid)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_transfer: got valid %b, expected no transfer", rs_if.valid);
         end else begin
            mon_exp = exp_q.pop_front();
            check_output("xfer_valid", 64'(rs_if.valid), 64'(mon_exp.lane_valid));
            for (int i = 0; i < 2; i++)
               if (mon_exp.lane_valid[i])
                  check_output($sformatf("xfer_uop%0d", i), 64'(rs_if.uop[i]), 64'(mon_exp.uop[i]));
         end
      end
   end

   uop_t z, ua0, ua1, ub0, ub1, uc0, ud0, ud1, ue0, ue0x, uk1, uk1x, uf0, uf0x, ug0, uh0;
   uop_t up0, up1, uq0, ur1;

   initial begin
      z    = make_uop(8'h00, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
      ua0  = make_uop(8'h11, 6'd20, 6'd5, 6'd6, 1'b0, 1'b1);
      ua1  = make_uop(8'h12, 6'd21, 6'd7, 6'd8, 1'b1, 1'b1);
      ub0  = make_uop(8'h21, 6'd22, 6'd1, 6'd2, 1'b0, 1'b0);
      ub1  = make_uop(8'h22, 6'd23, 6'd3, 6'd4, 1'b1, 1'b0);
      uc0  = make_uop(8'h23, 6'd24, 6'd10, 6'd11, 1'b0, 1'b1);
      ud0  = make_uop(8'h24, 6'd25, 6'd13, 6'd15, 1'b0, 1'b0);
      ud1  = make_uop(8'h25, 6'd26, 6'd16, 6'd17, 1'b0, 1'b0);
      ue0  = make_uop(8'h31, 6'd27, 6'd3, 6'd9, 1'b0, 1'b0);
      ue0x = make_uop(8'h31, 6'd27, 6'd3, 6'd9, 1'b0, 1'b1);
      uk1  = make_uop(8'h41, 6'd28, 6'd14, 6'd18, 1'b0, 1'b0);
      uk1x = make_uop(8'h41, 6'd28, 6'd14, 6'd18, 1'b1, 1'b0);
      uf0  = make_uop(8'h51, 6'd29, 6'd12, 6'd19, 1'b0, 1'b0);
      uf0x = make_uop(8'h51, 6'd29, 6'd12, 6'd19, 1'b1, 1'b0);
      ug0  = make_uop(8'h61, 6'd30, 6'd31, 6'd32, 1'b0, 1'b0);
      uh0  = make_uop(8'h62, 6'd33, 6'd34, 6'd35, 1'b0, 1'b0);
      up0  = make_uop(8'h71, 6'd36, 6'd37, 6'd38, 1'b1, 1'b0);
      up1  = make_uop(8'h72, 6'd39, 6'd40, 6'd41, 1'b0, 1'b1);
      uq0  = make_uop(8'h73, 6'd42, 6'd43, 6'd44, 1'b0, 1'b0);
      ur1  = make_uop(8'h74, 6'd45, 6'd46, 6'd47, 1'b1, 1'b1);

      rst = 1'b1; flush = 1'b0; rn_valid = 2'b00; rn_uop = {z, z}; rs_if.ready = 1'b0;
      cdb_if[0].valid = 1'b0; cdb_if[0].rd_phy = 6'd0;
      cdb_if[1].valid = 1'b0; cdb_if[1].rd_phy = 6'd0;

      // Reset: outputs held low while rst is high, accept right after release.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("rst_rn_ready", 64'(rn_ready), 64'd0);
      check_output("rst_valid", 64'(rs_if.valid), 64'd0);
      @(posedge clk); #1; rst = 1'b0; rs_if.ready = 1'b1;
      @(negedge clk);
      check_output("post_rst_rn_ready", 64'(rn_ready), 64'd1);
      check_output("post_rst_valid", 64'(rs_if.valid), 64'd0);

      // Single bundle, RS ready: valid one cycle after enqueue, fields unchanged.
      apply_stimulus(2'b11, ua1, ua0, 1'b1, 1'b0);
      exp_q.push_back(make_bundle(ua1, ua0, 2'b11));
      apply_stimulus(2'b00, z, z, 1'b1, 1'b0);
      @(negedge clk);
      check_output("a_valid", 64'(rs_if.valid), 64'd3);

      // Fill with RS stalled; third bundle refused; one ready cycle drains B.
      apply_stimulus(2'b11, ub1, ub0, 1'b0, 1'b0);
      exp_q.push_back(make_bundle(ub1, ub0, 2'b11));
      apply_stimulus(2'b01, z, uc0, 1'b0, 1'b0);
      exp_q.push_back(make_bundle(z, uc0, 2'b01));
      apply_stimulus(2'b11, ud1, ud0, 1'b0, 1'b0);
      @(negedge clk);
      check_output("full_rn_ready", 64'(rn_ready), 64'd0);
      apply_stimulus(2'b11, ud1, ud0, 1'b0, 1'b0);
      apply_stimulus(2'b00, z, z, 1'b1, 1'b0);
      apply_stimulus(2'b00, z, z, 1'b0, 1'b0);
      @(negedge clk);
      check_output("after_drain_rn_ready", 64'(rn_ready), 64'd1);
      check_output("head_c_valid", 64'(rs_if.valid), 64'd1);
      check_output("head_c_uop", 64'(rs_if.uop[0]), 64'(uc0));
      apply_stimulus(2'b00, z, z, 1'b1, 1'b0);
      apply_stimulus(2'b00, z, z, 1'b0, 1'b0);

      // Stored wakeup via cdb[1] survives after the broadcast ends.
      apply_stimulus(2'b01, z, ue0, 1'b0, 1'b0);
      exp_q.push_back(make_bundle(z, ue0x, 2'b01));
      apply_stimulus(2'b00, z, z, 1'b0, 1'b0);
      cdb_if[1].valid = 1'b1; cdb_if[1].rd_phy = 6'd9;
      apply_stimulus(2'b00, z, z, 1'b0, 1'b0);
      cdb_if[1].valid = 1'b0; cdb_if[1].rd_phy = 6'd0;
      @(negedge clk);
      check_output("stored_rs2_valid", 64'(rs_if.uop[0].rs2_valid), 64'd1);
      check_output("stored_rs1_untouched", 64'(rs_if.uop[0].rs1_valid), 64'd0);
      apply_stimulus(2'b00, z, z, 1'b1, 1'b0);

      // Broadcast in the enqueue cycle is captured for the incoming lane.
      apply_stimulus(2'b10, uk1, z, 1'b0, 1'b0);
      cdb_if[0].valid = 1'b1; cdb_if[0].rd_phy = 6'd14;
      exp_q.push_back(make_bundle(uk1x, z, 2'b10));
      apply_stimulus(2'b00, z, z, 1'b1, 1'b0);
      cdb_if[0].valid = 1'b0; cdb_if[0].rd_phy = 6'd0;

      // Same-cycle bypass on the output during the dequeue cycle.
      apply_stimulus(2'b01, z, uf0, 1'b0, 1'b0);
      exp_q.push_back(make_bundle(z, uf0x, 2'b01));
      apply_stimulus(2'b00, z, z, 1'b0, 1'b0);
      @(negedge clk);
      check_output("pre_bypass_rs1_valid", 64'(rs_if.uop[0].rs1_valid), 64'd0);
      apply_stimulus(2'b00, z, z, 1'b1, 1'b0);
      cdb_if[0].valid = 1'b1; cdb_if[0].rd_phy = 6'd12;
      apply_stimulus(2'b00, z, z, 1'b0, 1'b0);
      cdb_if[0].valid = 1'b0; cdb_if[0].rd_phy = 6'd0;

      // All-invalid bundle is not enqueued.
      apply_stimulus(2'b00, ud1, ud0, 1'b1, 1'b0);
      apply_stimulus(2'b00, z, z, 1'b1, 1'b0);
      @(negedge clk);
      check_output("empty_bundle_valid", 64'(rs_if.valid), 64'd0);

      // Flush with a concurrent enqueue while one bundle is buffered.
      apply_stimulus(2'b01, z, ug0, 1'b0, 1'b0);
      apply_stimulus(2'b01, z, uh0, 1'b0, 1'b1);
      apply_stimulus(2'b00, z, z, 1'b0, 1'b0);
      @(negedge clk);
      check_output("flush_valid", 64'(rs_if.valid), 64'd0);
      check_output("flush_rn_ready", 64'(rn_ready), 64'd1);
      apply_stimulus(2'b00, z, z, 1'b1, 1'b0);
      apply_stimulus(2'b00, z, z, 1'b1, 1'b0);

      // Back-to-back bundles with the RS always ready: one per cycle.
      apply_stimulus(2'b11, up1, up0, 1'b1, 1'b0);
      exp_q.push_back(make_bundle(up1, up0, 2'b11));
      @(negedge clk);
      check_output("stream_rn_ready0", 64'(rn_ready), 64'd1);
      apply_stimulus(2'b01, z, uq0, 1'b1, 1'b0);
      exp_q.push_back(make_bundle(z, uq0, 2'b01));
      @(negedge clk);
      check_output("stream_rn_ready1", 64'(rn_ready), 64'd1);
      apply_stimulus(2'b10, ur1, z, 1'b1, 1'b0);
      exp_q.push_back(make_bundle(ur1, z, 2'b10));
      @(negedge clk);
      check_output("stream_rn_ready2", 64'(rn_ready), 64'd1);
      apply_stimulus(2'b00, z, z, 1'b1, 1'b0);

      // Bounded wait for outstanding expected bundles.
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) apply_stimulus(2'b00, z, z, 1'b1, 1'b0);
      @(negedge clk);
      check_output("drain_left", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
